sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 19 +
 rtl/sram_arbiter_rr_arb2.sv | 18 +
 rtl/sram_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-port 32-bit over 16-bit SRAM arbiter.
// State encodings and default RAM geometry live here so the top and the bench agree.
package sram_arbiter_pkg;

   localparam int RAM_AW_DEF = 20;
   localparam int RAM_DW_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin pick, purely combinational; req[0]=instruction, req[1]=data.
// last is the port granted most recently; a lone requester always wins.
module rr_arb2
   import sram_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (last == OWN_D) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one 16-bit SRAM between instruction and data ports as two half accesses.
// gnt in cycle T gives rvalid at T+3; ports are held off (no gnt) while an access is in flight.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int RAM_AW = RAM_AW_DEF,
   parameter int RAM_DW = RAM_DW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic [3:0]        d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              ram_en,
   output logic [1:0]        ram_wen,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [RAM_DW-1:0] ram_wdata,
   input  logic [RAM_DW-1:0] ram_rdata
);

   state_t              state_q, state_d;
   owner_t              last_q, last_d;
   owner_t              owner_q, owner_d;
   logic [RAM_AW-2:0]   addr_q, addr_d;
   logic [3:0]          we_q, we_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [RAM_DW-1:0]   lo_q, lo_d;
   logic [31:0]         i_rdata_q, i_rdata_d;
   logic [31:0]         d_rdata_q, d_rdata_d;
   logic                i_rvalid_q, i_rvalid_d;
   logic                d_rvalid_q, d_rvalid_d;
   logic [1:0]          rr_gnt;
   logic                in_idle;

   // Byte-offset and high address bits alias away by design.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_addr[31:RAM_AW+1], i_addr[1:0],
                               d_addr[31:RAM_AW+1], d_addr[1:0]};

   rr_arb2 u_rr (
      .req  ({d_req, i_req}),
      .last (last_q),
      .gnt  (rr_gnt)
   );

   assign in_idle = (state_q == ST_IDLE);
   assign i_gnt   = in_idle & rr_gnt[0];
   assign d_gnt   = in_idle & rr_gnt[1];

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      lo_d       = lo_q;
      i_rdata_d  = i_rdata_q;
      d_rdata_d  = d_rdata_q;
      i_rvalid_d = 1'b0;
      d_rvalid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (d_gnt) begin
               state_d = ST_LO;
               owner_d = OWN_D;
               last_d  = OWN_D;
               addr_d  = d_addr[RAM_AW:2];
               we_d    = d_we;
               wdata_d = d_wdata;
            end else if (i_gnt) begin
               state_d = ST_LO;
               owner_d = OWN_I;
               last_d  = OWN_I;
               addr_d  = i_addr[RAM_AW:2];
               we_d    = 4'b0000;
               wdata_d = 32'h0;
            end
         end
         ST_LO: begin
            state_d = ST_HI;
            lo_d    = ram_rdata;
         end
         ST_HI: begin
            // Port rdata only changes together with its rvalid.
            state_d = ST_IDLE;
            if (owner_q == OWN_D) begin
               d_rvalid_d = 1'b1;
               d_rdata_d  = {ram_rdata, lo_q};
            end else begin
               i_rvalid_d = 1'b1;
               i_rdata_d  = {ram_rdata, lo_q};
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         last_q     <= OWN_I;
         owner_q    <= OWN_I;
         addr_q     <= '0;
         we_q       <= 4'b0000;
         wdata_q    <= 32'h0;
         lo_q       <= '0;
         i_rdata_q  <= 32'h0;
         d_rdata_q  <= 32'h0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         lo_q       <= lo_d;
         i_rdata_q  <= i_rdata_d;
         d_rdata_q  <= d_rdata_d;
         i_rvalid_q <= i_rvalid_d;
         d_rvalid_q <= d_rvalid_d;
      end
   end

   // RAM side decodes straight from state so a reset drops ram_en at once.
   always_comb begin
      ram_en    = 1'b0;
      ram_wen   = 2'b00;
      ram_addr  = '0;
      ram_wdata = '0;
      if (state_q == ST_LO) begin
         ram_en    = 1'b1;
         ram_wen   = we_q[1:0];
         ram_addr  = {addr_q, 1'b0};
         ram_wdata = wdata_q[RAM_DW-1:0];
      end else if (state_q == ST_HI) begin
         ram_en    = 1'b1;
         ram_wen   = we_q[3:2];
         ram_addr  = {addr_q, 1'b1};
         ram_wdata = wdata_q[2*RAM_DW-1:RAM_DW];
      end
   end

   assign i_rvalid = i_rvalid_q;
   assign d_rvalid = d_rvalid_q;
   assign i_rdata  = i_rdata_q;
   assign d_rdata  = d_rdata_q;

endmodule
